// File: rtl/sa_feed_pkg.sv
// Shared types and default geometry for the systolic-array input feeder.
package sa_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } feed_state_t;

  localparam int DEF_HPE   = 64;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_KW    = 16;

  // Zero-padding needed for the last operand pair to cross the whole array.
  function automatic int drain_cyc_default(input int hpe);
    return 2 * hpe + 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth WIDTH-bit delay line; one per lane gives the triangular skew.
module sa_skew_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset (not just the tail) so the array never sees
  // stale operands after a mid-tile reset; the flops are cheap at this depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking keeps this a true shift; blocking would collapse
      // all stages into one cycle.
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Tile sequencer plus skewed A/B staging for the output-stationary array.
module sa_skew_feeder
  import sa_feed_pkg::*;
#(
  parameter int HPE       = DEF_HPE,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int KW        = DEF_KW,
  parameter int DRAIN_CYC = drain_cyc_default(HPE)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*HPE-1:0] a_vec,
  input  logic [WIDTH*HPE-1:0] b_vec,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*HPE-1:0] BB,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  feed_state_t   state, state_next;
  logic [KW-1:0] k_q;
  logic [KW-1:0] acc_cnt;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          take_start;

  assign accept     = in_valid & in_ready;
  assign take_start = (state == ST_IDLE) && start;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = (k_len == '0) ? ST_DRAIN : ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (accept && (acc_cnt + KW'(1) == k_q)) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DW'(DRAIN_CYC)) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Drain counts 1..DRAIN_CYC after a loaded tile; a zero tile starts at 0,
  // giving it one extra cycle so done lands at start+DRAIN_CYC+2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      k_q       <= '0;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      acc_clr   <= 1'b0;
    end else begin
      state   <= state_next;
      acc_clr <= take_start;
      if (take_start) begin
        k_q       <= k_len;
        acc_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + KW'(1);
        if (state == ST_LOAD && state_next == ST_DRAIN) drain_cnt <= DW'(1);
        else if (state == ST_DRAIN)                     drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  // Non-accept cycles inject zeros, so bubbles and drain add nothing to MACs.
  for (genvar z = 0; z < HPE; z++) begin : g_lane
    sa_skew_line #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_a (
      .CLK     (CLK),
      .RST     (RST),
      .data    (accept ? a_vec[z*WIDTH +: WIDTH] : '0),
      .delayed (AA[z*WIDTH +: WIDTH])
    );
    sa_skew_line #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_b (
      .CLK     (CLK),
      .RST     (RST),
      .data    (accept ? b_vec[z*WIDTH +: WIDTH] : '0),
      .delayed (BB[z*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder at HPE=4, with a 4x4 array stand-in.
`timescale 1ns/1ps
module tb_sa_skew_feeder;
  import sa_feed_pkg::*;

  localparam int HPE       = 4;
  localparam int WIDTH     = 8;
  localparam int KW        = 16;
  localparam int DRAIN_CYC = drain_cyc_default(HPE);
  localparam int BW        = HPE * WIDTH;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] a_vec = '0;
  logic [BW-1:0] b_vec = '0;
  logic          in_ready, acc_clr, busy, done;
  logic [BW-1:0] AA, BB;

  sa_skew_feeder #(.HPE(HPE), .WIDTH(WIDTH), .KW(KW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .AA       (AA),
    .BB       (BB),
    .acc_clr  (acc_clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acc, last_acc, s_cyc;
  int n_clr  = 0;
  bit mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (acc_clr === 1'b1) n_clr++;

  typedef struct {
    int               cyc;
    int               lane;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: each lane must show its accepted operand exactly at its
  // skewed cycle and zero at every other cycle.
  always @(negedge CLK) begin : monitor
    logic [BW-1:0] ea, eb;
    if (mon_en && !RST) begin
      ea = '0;
      eb = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          ea[sb[i].lane*WIDTH +: WIDTH] = sb[i].a;
          eb[sb[i].lane*WIDTH +: WIDTH] = sb[i].b;
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL sb_stale lane=%0d cyc=%0d expected at %0d", sb[i].lane, cyc, sb[i].cyc);
          sb.delete(i);
        end
      end
      checks++;
      if (AA !== ea) begin
        errors++;
        $display("FAIL skew_AA cyc=%0d got=%h exp=%h", cyc, AA, ea);
      end
      checks++;
      if (BB !== eb) begin
        errors++;
        $display("FAIL skew_BB cyc=%0d got=%h exp=%h", cyc, BB, eb);
      end
    end
  end

  // Behavioural 4x4 output-stationary array: A flows right, B flows down.
  logic [WIDTH-1:0] a_r [HPE][HPE];
  logic [WIDTH-1:0] b_r [HPE][HPE];
  logic [WIDTH-1:0] a_in [HPE][HPE];
  logic [WIDTH-1:0] b_in [HPE][HPE];
  logic [15:0]      y [HPE][HPE];

  always_comb begin
    for (int i = 0; i < HPE; i++) begin
      for (int j = 0; j < HPE; j++) begin
        if (j == 0) a_in[i][j] = AA[i*WIDTH +: WIDTH];
        else        a_in[i][j] = a_r[i][j-1];
        if (i == 0) b_in[i][j] = BB[j*WIDTH +: WIDTH];
        else        b_in[i][j] = b_r[i-1][j];
      end
    end
  end

  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < HPE; i++) begin
      for (int j = 0; j < HPE; j++) begin
        if (RST || acc_clr) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          y[i][j]   <= '0;
        end else begin
          a_r[i][j] <= a_in[i][j];
          b_r[i][j] <= b_in[i][j];
          y[i][j]   <= y[i][j] + 16'(a_in[i][j]) * 16'(b_in[i][j]);
        end
      end
    end
  end

  task automatic push_vec(input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    for (int z = 0; z < HPE; z++) begin
      e.cyc  = cyc + 1 + z;
      e.lane = z;
      e.a    = a[z*WIDTH +: WIDTH];
      e.b    = b[z*WIDTH +: WIDTH];
      sb.push_back(e);
    end
  endtask

  // Drives one cycle of input; called at a falling edge, returns at the next.
  task automatic send(input bit v, input logic [BW-1:0] a, input logic [BW-1:0] b);
    in_valid = v;
    a_vec    = a;
    b_vec    = b;
    if (v && in_ready === 1'b1) begin
      push_vec(a, b);
      n_acc++;
      last_acc = cyc;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
  endtask

  task automatic start_tile(input int k);
    start = 1'b1;
    k_len = KW'(k);
    s_cyc = cyc;
    n_acc = 0;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (acc_clr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL acc_clr_at_start cyc=%0d acc_clr=%b busy=%b exp 1 1", cyc, acc_clr, busy);
    end
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input bit chk_y);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_in_ready_drain cyc=%0d got=%b exp=0", name, cyc, in_ready);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout cyc=%0d exp done at %0d", name, cyc, exp_cyc);
    end else if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle got=%0d exp=%0d", name, cyc, exp_cyc);
    end
    if (seen && chk_y) begin
      for (int i = 0; i < HPE; i++) begin
        for (int j = 0; j < HPE; j++) begin
          checks++;
          if (y[i][j] !== 16'd30) begin
            errors++;
            $display("FAIL %s_y[%0d][%0d] got=%0d exp=30", name, i, j, y[i][j]);
          end
        end
      end
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done done=%b busy=%b exp 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if (AA !== '0 || BB !== '0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || acc_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs AA=%h BB=%h rdy=%b busy=%b done=%b clr=%b exp all 0",
               AA, BB, in_ready, busy, done, acc_clr);
    end
    RST    = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
  endtask

  task automatic test_skew();
    start_tile(1);
    send(1'b1, 32'h04030201, 32'h08070605);
    wait_done("skew", last_acc + DRAIN_CYC + 1, 1'b0);
  endtask

  task automatic test_bubble();
    int exp_done;
    start_tile(3);
    send(1'b1, 32'h14131211, 32'h94939291);
    send(1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
    send(1'b1, 32'h24232221, 32'hA4A3A2A1);
    send(1'b1, 32'h34333231, 32'hB4B3B2B1);
    exp_done = last_acc + DRAIN_CYC + 1;
    send(1'b1, 32'h44434241, 32'hC4C3C2C1);
    checks++;
    if (n_acc != 3) begin
      errors++;
      $display("FAIL bubble_accepts got=%0d exp=3", n_acc);
    end
    wait_done("bubble", exp_done, 1'b0);
  endtask

  task automatic test_zero_tile();
    int clr0;
    clr0 = n_clr;
    start_tile(0);
    wait_done("zero", s_cyc + DRAIN_CYC + 2, 1'b0);
    checks++;
    if (n_clr - clr0 != 1) begin
      errors++;
      $display("FAIL zero_clr_pulses got=%0d exp=1", n_clr - clr0);
    end
  endtask

  task automatic test_start_ignored();
    int clr0, exp_done;
    clr0 = n_clr;
    start_tile(2);
    send(1'b1, 32'h05050505, 32'h06060606);
    start = 1'b1;
    k_len = KW'(7);
    send(1'b1, 32'h07070707, 32'h09090909);
    start = 1'b0;
    exp_done = last_acc + DRAIN_CYC + 1;
    start = 1'b1;
    k_len = '0;
    send(1'b1, 32'h0B0B0B0B, 32'h0C0C0C0C);
    start = 1'b0;
    checks++;
    if (n_acc != 2) begin
      errors++;
      $display("FAIL ignored_accepts got=%0d exp=2", n_acc);
    end
    wait_done("ignored", exp_done, 1'b0);
    checks++;
    if (n_clr - clr0 != 1) begin
      errors++;
      $display("FAIL ignored_clr_pulses got=%0d exp=1", n_clr - clr0);
    end
  endtask

  task automatic test_back_to_back();
    start_tile(1);
    send(1'b1, 32'h11223344, 32'h55667788);
    wait_done("b2b_first", last_acc + DRAIN_CYC + 1, 1'b0);
    start_tile(2);
    send(1'b1, 32'h01020304, 32'h0A0B0C0D);
    send(1'b1, 32'hF1F2F3F4, 32'hE1E2E3E4);
    wait_done("b2b_second", last_acc + DRAIN_CYC + 1, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    start_tile(3);
    send(1'b1, 32'h21222324, 32'h31323334);
    send(1'b1, 32'h41424344, 32'h51525354);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (AA !== '0 || BB !== '0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || acc_clr !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset AA=%h BB=%h rdy=%b busy=%b done=%b clr=%b exp all 0",
               AA, BB, in_ready, busy, done, acc_clr);
    end
    sb.delete();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
    start_tile(1);
    send(1'b1, 32'h61626364, 32'h71727374);
    wait_done("restart", last_acc + DRAIN_CYC + 1, 1'b0);
  endtask

  task automatic test_array();
    start_tile(5);
    for (int i = 0; i < 5; i++) send(1'b1, {HPE{8'd2}}, {HPE{8'd3}});
    wait_done("array", last_acc + DRAIN_CYC + 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_skew();
    test_bubble();
    test_zero_tile();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_load();
    test_array();
    repeat (2) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover entries=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sa_skew_feeder.md
# sa_skew_feeder

Input staging block that sits directly upstream of the 2D output-stationary systolic array and drives its `AA`/`BB` edge buses. It accepts one A row-vector and one B column-vector per handshake and emits them with a triangular skew: lane z is delayed z cycles relative to lane 0. This lines up matching operands inside every PE. It counts the K vectors of one matrix tile, pads with zeros while the wavefront drains, pulses an accumulator clear at tile start, and signals `done` when every PE holds its final MAC result.

## Interface
- `HPE`, 64, lanes per bus; equals the array's HPE (and VPE).
- `WIDTH`, 8, operand width per lane.
- `KW`, 16, width of the tile-length field.
- `DRAIN_CYC`, 2*HPE+1, zero-padding cycles after the last accepted vector.
- `CLK`  in  1  clock; all state is rising-edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  KW  vectors in the tile; sampled with `start`.
- `in_valid`  in  1  `a_vec`/`b_vec` valid.
- `in_ready`  out  1  feeder accepts a vector this cycle.
- `a_vec`  in  WIDTH*HPE  A lanes; lane z = bits [(z+1)*WIDTH-1 : z*WIDTH].
- `b_vec`  in  WIDTH*HPE  B lanes; same packing.
- `AA`  out  WIDTH*HPE  skewed A to the array.
- `BB`  out  WIDTH*HPE  skewed B to the array.
- `acc_clr`  out  1  one-cycle pulse; system ORs it into the array reset.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when tile results are final.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE → LOAD on `start` with `k_len`≠0. IDLE → DRAIN on `start` with `k_len`=0.
- `acc_clr` pulses in the cycle after `start` is taken, whichever state follows.
- LOAD: `in_ready`=1. Accept = `in_valid & in_ready`. Each accept increments the accept counter. LOAD → DRAIN in the cycle after the k_len-th accept.
- Bubbles: a LOAD cycle without an accept pushes an all-zero vector into both A and B. Alignment is preserved and the zero product adds nothing. The skew pipeline never stalls and the array has no enable.
- DRAIN: `in_ready`=0. Zeros are pushed for DRAIN_CYC cycles, then DRAIN → DONE.
- DONE: `done`=1 for one cycle, then → IDLE.
- `start` outside IDLE is ignored. `k_len` is captured only at `start`.
- In IDLE the pipeline is still fed zeros, so `AA`/`BB` settle to 0.
- Datapath: lane z is a shift line of depth z+1, both A and B. No arithmetic and no width change.
- Reset (any state, including mid-LOAD or mid-DRAIN):
  - all skew registers and counters clear;
  - state goes to IDLE;
  - `AA`=`BB`=0, `in_ready`=`busy`=`done`=`acc_clr`=0.

## Timing
- Lane skew: `AA` lane z at cycle t = `a_vec` lane z accepted at cycle t−1−z, or 0 if no accept happened in that cycle. `BB` follows the same rule.
- `in_ready` is registered from state, never combinational on `in_valid`.
- With last accept at cycle L, `done` is high in cycle L+DRAIN_CYC+1.
- For `k_len`=0, with `start` at cycle S, `done` is high at S+DRAIN_CYC+2.
- `acc_clr` (cycle S+1) precedes the earliest nonzero `AA` (at or after S+2).
- Back-to-back tiles: `start` is honoured in the cycle after `done`.

## Structure
- Package `sa_feed_pkg` holds:
  - the state enum `feed_state_t`;
  - the default `HPE`/`WIDTH`/`KW`;
  - the function giving the default `DRAIN_CYC`.
- Sub-module `sa_skew_line`: one WIDTH-bit delay line with parameter `DEPTH`, async-reset to 0. It is instantiated 2×HPE times with DEPTH=z+1.
- The top level holds the FSM, the accept counter (KW bits) and the drain counter (wide enough for DRAIN_CYC).

## Test plan
- Reset: assert `RST` mid-LOAD with HPE=4 → next edge shows `AA`=`BB`=0, `in_ready`=0, `busy`=0; a later `start` restarts cleanly.
- Skew, HPE=4, `k_len`=1: `a_vec` lanes {3:4, 2:3, 1:2, 0:1} accepted at cycle c → `AA` lane0=1 at c+1, lane1=2 at c+2, lane2=3 at c+3, lane3=4 at c+4, and 0 on every lane at all other cycles.
- Bubble, `k_len`=3: `in_valid` low for one cycle between vectors 1 and 2 → a zero column appears on every lane at the correct skewed offsets; exactly 3 accepts; `done` at L+DRAIN_CYC+1.
- Zero tile: `start` with `k_len`=0 → `acc_clr` at S+1, `in_ready` never high, `done` at S+DRAIN_CYC+2.
- `start` asserted during LOAD and DRAIN → ignored; accept count and `done` timing unchanged.
- End to end with the array at HPE=VPE=4: all A lanes=2, all B lanes=3, `k_len`=5 → at `done`, every 16-bit `Y` element equals 30.
